// File: rtl/bpc_pkg.sv
// Shared width defaults and arbiter state type for the BPC code-buffer arbiter.
package bpc_pkg;

   localparam int BPC_N_REQ   = 4;
   localparam int BPC_DATA_W  = 146;
   localparam int BPC_SIZE_W  = 8;
   localparam int BPC_TSIZE_W = 11;
   localparam int BPC_CNT_W   = 16;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_XFER  = 2'd1,
      ARB_DRAIN = 2'd2
   } arb_state_e;

endpackage

// File: rtl/bpc_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping N-1 -> 0.
module bpc_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_oh,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);

   int lane;

   // Walk offsets from farthest to nearest so the nearest set request is the last one written.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      any     = 1'b0;
      lane    = 0;
      for (int off = N - 1; off >= 0; off--) begin
         lane = (int'(ptr) + off) % N;
         if (req[lane]) begin
            gnt_oh       = '0;
            gnt_oh[lane] = 1'b1;
            gnt_idx      = IW'(lane);
            any          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bpc_codebuf_arb.sv
// Block-granular round-robin arbiter sharing one BPC code buffer among N_REQ encoder lanes.
// Optional per-lane statistics outputs are built when BPC_ARB_STATS_EN is defined.
module bpc_codebuf_arb
   import bpc_pkg::*;
#(
   parameter int N_REQ   = BPC_N_REQ,
   parameter int DATA_W  = BPC_DATA_W,
   parameter int SIZE_W  = BPC_SIZE_W,
   parameter int TSIZE_W = BPC_TSIZE_W,
   parameter int CNT_W   = BPC_CNT_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ*DATA_W-1:0]     req_data_i,
   input  logic [N_REQ*SIZE_W-1:0]     req_size_i,
   input  logic [N_REQ-1:0]            req_valid_i,
   input  logic [N_REQ-1:0]            req_sop_i,
   input  logic [N_REQ-1:0]            req_eop_i,
   output logic [N_REQ-1:0]            req_ready_o,
   output logic [DATA_W-1:0]           cb_data_o,
   output logic [SIZE_W-1:0]           cb_size_o,
   output logic                        cb_valid_o,
   output logic                        cb_sop_o,
   output logic                        cb_eop_o,
   input  logic                        cb_ready_i,
   input  logic                        cb_svalid_i,
   input  logic [TSIZE_W-1:0]          cb_tsize_i,
   output logic                        blk_valid_o,
   output logic [$clog2(N_REQ)-1:0]    blk_id_o,
   output logic [TSIZE_W-1:0]          blk_size_o,
`ifdef BPC_ARB_STATS_EN
   output logic [N_REQ*CNT_W-1:0]           stat_blk_o,
   output logic [N_REQ*(CNT_W+TSIZE_W)-1:0] stat_bits_o,
`endif
   output logic                        busy_o,
   output logic                        err_o
);

   localparam int IW = $clog2(N_REQ);

   arb_state_e        state_reg, state_next;
   logic [IW-1:0]     gnt_reg;
   logic [N_REQ-1:0]  gnt_oh_reg;
   logic [IW-1:0]     rr_ptr_reg;
   logic              first_beat_reg;
   logic              blk_valid_reg;
   logic [IW-1:0]     blk_id_reg;
   logic [TSIZE_W-1:0] blk_size_reg;
   logic              err_reg;

   logic              beat_acc;
   logic              err_set;
   logic [N_REQ-1:0]  pick_oh;
   logic [IW-1:0]     pick_idx;
   logic              pick_any;

   logic [DATA_W-1:0] lane_data [N_REQ];
   logic [SIZE_W-1:0] lane_size [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
         assign lane_data[gi] = req_data_i[gi*DATA_W +: DATA_W];
         assign lane_size[gi] = req_size_i[gi*SIZE_W +: SIZE_W];
      end
   endgenerate

   bpc_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req     (req_valid_i),
      .ptr     (rr_ptr_reg),
      .gnt_oh  (pick_oh),
      .gnt_idx (pick_idx),
      .any     (pick_any)
   );

   always_comb begin
      state_next  = state_reg;
      cb_data_o   = lane_data[gnt_reg];
      cb_size_o   = lane_size[gnt_reg];
      cb_sop_o    = req_sop_i[gnt_reg];
      cb_eop_o    = req_eop_i[gnt_reg];
      cb_valid_o  = 1'b0;
      req_ready_o = '0;
      beat_acc    = 1'b0;
      err_set     = 1'b0;
      case (state_reg)
         ARB_IDLE: begin
            if (pick_any) state_next = ARB_XFER;
         end
         ARB_XFER: begin
            cb_valid_o  = req_valid_i[gnt_reg];
            req_ready_o = gnt_oh_reg & {N_REQ{cb_ready_i}};
            beat_acc    = req_valid_i[gnt_reg] & cb_ready_i;
            if (beat_acc) begin
               // sop must mark exactly the first accepted beat of the grant
               if (first_beat_reg != cb_sop_o) err_set = 1'b1;
               if (cb_eop_o) state_next = ARB_DRAIN;
            end
         end
         ARB_DRAIN: begin
            if (cb_svalid_i) state_next = ARB_IDLE;
         end
         default: state_next = ARB_IDLE;
      endcase
      if (cb_svalid_i && (state_reg != ARB_DRAIN)) err_set = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ARB_IDLE;
         gnt_reg        <= '0;
         gnt_oh_reg     <= '0;
         rr_ptr_reg     <= '0;
         first_beat_reg <= 1'b0;
         blk_valid_reg  <= 1'b0;
         blk_id_reg     <= '0;
         blk_size_reg   <= '0;
         err_reg        <= 1'b0;
      end else begin
         state_reg     <= state_next;
         blk_valid_reg <= 1'b0;
         if (err_set) err_reg <= 1'b1;
         if ((state_reg == ARB_IDLE) && pick_any) begin
            gnt_reg        <= pick_idx;
            gnt_oh_reg     <= pick_oh;
            first_beat_reg <= 1'b1;
         end
         if (beat_acc) first_beat_reg <= 1'b0;
         if ((state_reg == ARB_DRAIN) && cb_svalid_i) begin
            blk_valid_reg <= 1'b1;
            blk_id_reg    <= gnt_reg;
            blk_size_reg  <= cb_tsize_i;
            rr_ptr_reg    <= (gnt_reg == IW'(N_REQ - 1)) ? '0 : gnt_reg + 1'b1;
         end
      end
   end

   assign blk_valid_o = blk_valid_reg;
   assign blk_id_o    = blk_id_reg;
   assign blk_size_o  = blk_size_reg;
   assign busy_o      = (state_reg != ARB_IDLE);
   assign err_o       = err_reg;

`ifdef BPC_ARB_STATS_EN
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
         logic [CNT_W-1:0]         blk_cnt_reg;
         logic [CNT_W+TSIZE_W-1:0] bit_cnt_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               blk_cnt_reg <= '0;
               bit_cnt_reg <= '0;
            end else if (blk_valid_reg && (blk_id_reg == IW'(gi))) begin
               blk_cnt_reg <= blk_cnt_reg + 1'b1;
               bit_cnt_reg <= bit_cnt_reg + {{CNT_W{1'b0}}, blk_size_reg};
            end
         end
         assign stat_blk_o[gi*CNT_W +: CNT_W]                       = blk_cnt_reg;
         assign stat_bits_o[gi*(CNT_W+TSIZE_W) +: (CNT_W+TSIZE_W)] = bit_cnt_reg;
      end
   endgenerate
`endif

endmodule

// File: tb/tb_bpc_codebuf_arb.sv
// Randomized scoreboard bench for bpc_codebuf_arb: lane block queues, code-buffer model, result queue.
`timescale 1ns/1ps
module tb_bpc_codebuf_arb;

   localparam int N    = 4;
   localparam int DW   = 146;
   localparam int SW   = 8;
   localparam int TW   = 11;
   localparam int CW   = 16;
   localparam int IW   = 2;
   localparam int HALF = 5;
   localparam int M_IDLE = 0, M_XFER = 1, M_DRAIN = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N*DW-1:0]   req_data_i = '0;
   logic [N*SW-1:0]   req_size_i = '0;
   logic [N-1:0]      req_valid_i = '0;
   logic [N-1:0]      req_sop_i = '0;
   logic [N-1:0]      req_eop_i = '0;
   logic [N-1:0]      req_ready_o;
   logic [DW-1:0]     cb_data_o;
   logic [SW-1:0]     cb_size_o;
   logic              cb_valid_o, cb_sop_o, cb_eop_o;
   logic              cb_ready_i = 1'b0;
   logic              cb_svalid_i = 1'b0;
   logic [TW-1:0]     cb_tsize_i = '0;
   logic              blk_valid_o;
   logic [IW-1:0]     blk_id_o;
   logic [TW-1:0]     blk_size_o;
   logic              busy_o, err_o;
`ifdef BPC_ARB_STATS_EN
   logic [N*CW-1:0]      stat_blk_o;
   logic [N*(CW+TW)-1:0] stat_bits_o;
   logic [CW-1:0]        m_blk  [N];
   logic [CW+TW-1:0]     m_bits [N];
`endif

   always #HALF clk = ~clk;

   bpc_codebuf_arb dut (
      .clk         (clk),
      .rst         (rst),
      .req_data_i  (req_data_i),
      .req_size_i  (req_size_i),
      .req_valid_i (req_valid_i),
      .req_sop_i   (req_sop_i),
      .req_eop_i   (req_eop_i),
      .req_ready_o (req_ready_o),
      .cb_data_o   (cb_data_o),
      .cb_size_o   (cb_size_o),
      .cb_valid_o  (cb_valid_o),
      .cb_sop_o    (cb_sop_o),
      .cb_eop_o    (cb_eop_o),
      .cb_ready_i  (cb_ready_i),
      .cb_svalid_i (cb_svalid_i),
      .cb_tsize_i  (cb_tsize_i),
      .blk_valid_o (blk_valid_o),
      .blk_id_o    (blk_id_o),
      .blk_size_o  (blk_size_o),
`ifdef BPC_ARB_STATS_EN
      .stat_blk_o  (stat_blk_o),
      .stat_bits_o (stat_bits_o),
`endif
      .busy_o      (busy_o),
      .err_o       (err_o)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [SW-1:0] size;
      logic          sop;
      logic          eop;
   } beat_t;

   typedef struct {
      int            id;
      logic [TW-1:0] size;
      longint        due;
   } res_t;

   beat_t  lq [N][$];
   res_t   exp_q[$];
   int     vectors = 0, miscompares = 0;
   int     phase = M_IDLE, cur = 0, ptr = 0, nbeat = 0;
   logic [TW-1:0] sum = '0, sv_size = '0;
   bit     sv_pending = 0, err_exp = 0, err_pend = 0, spur_req = 0, stall_req = 0, rst_req = 0;
   int     sv_delay = 0, stall_left = 0;
   int     gap_pct = 0, ready_pct = 100, max_delay = 0;
   logic [N-1:0] lane_on = '0, acc_prev = '0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Round-robin rule: first valid lane at or after ptr, wrapping.
   function automatic int rr_rule(input logic [N-1:0] v, input int p);
      for (int off = 0; off < N; off++)
         if (v[(p + off) % N]) return (p + off) % N;
      return 0;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [159:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   // flags: 0 normal, 1 first beat lacks sop, 2 last beat also carries sop
   task automatic add_block(input int lane, input int nb, input int sz, input int flags);
      beat_t b;
      for (int i = 0; i < nb; i++) begin
         b.data = rand_data();
         b.size = (sz < 0) ? SW'($urandom_range(255)) : SW'(sz);
         b.sop  = (i == 0) && (flags != 1);
         if ((flags == 2) && (i == nb - 1)) b.sop = 1'b1;
         b.eop  = (i == nb - 1);
         lq[lane].push_back(b);
      end
   endtask

   function automatic bit all_empty();
      for (int k = 0; k < N; k++) if (lq[k].size() != 0) return 0;
      return 1;
   endfunction

   task automatic step();
      beat_t h;
      logic [N-1:0] rdy;
      logic exp_cv;
      res_t r;
      @(negedge clk);
      for (int k = 0; k < N; k++)
         if (acc_prev[k]) begin
            h = lq[k].pop_front();
            lane_on[k] = 1'b0;
         end
      rst         = rst_req;
      cb_svalid_i = 1'b0;
      cb_tsize_i  = TW'($urandom());
      if (!rst_req) begin
         if (spur_req && (phase == M_XFER)) begin
            cb_svalid_i = 1'b1;
            spur_req    = 0;
            err_pend    = 1;
         end else if (sv_pending) begin
            if (sv_delay > 0) sv_delay--;
            else begin
               cb_svalid_i = 1'b1;
               cb_tsize_i  = sv_size;
               sv_pending  = 0;
               r.id = cur; r.size = sv_size; r.due = longint'($time) + 3*HALF - 1;
               exp_q.push_back(r);
               ptr = (cur + 1) % N;
`ifdef BPC_ARB_STATS_EN
               m_blk[cur]  = m_blk[cur] + 1'b1;
               m_bits[cur] = m_bits[cur] + (CW+TW)'(sv_size);
`endif
            end
         end
      end
      if (stall_left > 0) begin
         cb_ready_i = 1'b0;
         stall_left--;
      end else cb_ready_i = ($urandom_range(99) < ready_pct);
      for (int k = 0; k < N; k++) begin
         if (rst_req) lane_on[k] = 1'b0;
         else if (!lane_on[k] && (lq[k].size() > 0) && ($urandom_range(99) >= gap_pct)) lane_on[k] = 1'b1;
         req_valid_i[k] = lane_on[k];
         if (lq[k].size() > 0) begin
            h = lq[k][0];
            req_data_i[k*DW +: DW] = h.data;
            req_size_i[k*SW +: SW] = h.size;
            req_sop_i[k] = h.sop;
            req_eop_i[k] = h.eop;
         end else begin
            req_data_i[k*DW +: DW] = '0;
            req_size_i[k*SW +: SW] = '0;
            req_sop_i[k] = 1'b0;
            req_eop_i[k] = 1'b0;
         end
      end
      #(HALF - 1);
      if (rst_req) begin
         rst_req = 0; phase = M_IDLE; ptr = 0; cur = 0; sum = '0; nbeat = 0;
         err_exp = 0; err_pend = 0; sv_pending = 0; acc_prev = '0;
         exp_q.delete();
         for (int k = 0; k < N; k++) begin
            lq[k].delete();
`ifdef BPC_ARB_STATS_EN
            m_blk[k] = '0; m_bits[k] = '0;
`endif
         end
         return;
      end
      rdy = '0;
      if ((phase == M_XFER) && cb_ready_i) rdy[cur] = 1'b1;
      chk("req_ready", DW'(req_ready_o), DW'(rdy));
      chk("busy", DW'(busy_o), DW'(phase != M_IDLE));
      chk("err", DW'(err_o), DW'(err_exp));
      exp_cv = (phase == M_XFER) && lane_on[cur];
      chk("cb_valid", DW'(cb_valid_o), DW'(exp_cv));
      if (exp_cv) begin
         h = lq[cur][0];
         chk("cb_data", cb_data_o, h.data);
         chk("cb_size", DW'(cb_size_o), DW'(h.size));
         chk("cb_sop", DW'(cb_sop_o), DW'(h.sop));
         chk("cb_eop", DW'(cb_eop_o), DW'(h.eop));
      end
      acc_prev = req_valid_i & req_ready_o;
      if (err_pend) begin err_exp = 1; err_pend = 0; end
      case (phase)
         M_IDLE: if (|req_valid_i) begin
            cur = rr_rule(req_valid_i, ptr);
            phase = M_XFER;
            nbeat = 0;
         end
         M_XFER: if (acc_prev[cur]) begin
            h = lq[cur][0];
            if ((nbeat == 0) != h.sop) err_exp = 1;
            nbeat++;
            sum = sum + TW'(h.size);
            if (stall_req) begin stall_req = 0; stall_left = 5; end
            if (h.eop) begin
               phase = M_DRAIN; sv_pending = 1; sv_delay = $urandom_range(max_delay);
               sv_size = sum; sum = '0;
            end
         end
         M_DRAIN: if (cb_svalid_i) phase = M_IDLE;
         default: phase = M_IDLE;
      endcase
   endtask

   task automatic run_quiet(input int bound);
      int n = 0;
      while (!((phase == M_IDLE) && !sv_pending && all_empty() && (exp_q.size() == 0)) && (n < bound)) begin
         step();
         n++;
      end
      vectors++;
      if (n >= bound) begin
         miscompares++;
         $display("FAIL run_timeout: got %0d cycles expected under %0d", n, bound);
      end
      repeat (2) step();
   endtask

   task automatic do_reset();
      rst_req = 1;
      step();
   endtask

   // Result monitor: one line per completed block, checked against the scoreboard queue.
   initial begin
      res_t r;
      forever begin
         @(negedge clk);
         #(HALF - 1);
         if (!rst && blk_valid_o) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL blk_unexpected: got id=%0d size=%0d expected no block", blk_id_o, blk_size_o);
            end else begin
               r = exp_q.pop_front();
               chk("blk_id", DW'(blk_id_o), DW'(r.id));
               chk("blk_size", DW'(blk_size_o), DW'(r.size));
               chk("blk_time", DW'($time), DW'(r.due));
               $display("block lane=%0d size=%0d t=%0t", blk_id_o, blk_size_o, $time);
            end
         end
      end
   end

   initial begin
      int n;
`ifdef BPC_ARB_STATS_EN
      for (int k = 0; k < N; k++) begin m_blk[k] = '0; m_bits[k] = '0; end
`endif
      repeat (3) @(negedge clk);
      #(HALF - 1);
      chk("rst_busy", DW'(busy_o), '0);
      chk("rst_err", DW'(err_o), '0);
      chk("rst_blk_valid", DW'(blk_valid_o), '0);
      chk("rst_blk_id", DW'(blk_id_o), '0);
      chk("rst_blk_size", DW'(blk_size_o), '0);
      chk("rst_cb_valid", DW'(cb_valid_o), '0);
      chk("rst_req_ready", DW'(req_ready_o), '0);

      // all lanes pending from reset: grants 0,1,2,3,0,1,2,3
      for (int b = 0; b < 2; b++)
         for (int k = 0; k < N; k++) add_block(k, $urandom_range(1, 3), -1, 0);
      run_quiet(500);

      // lane 2 alone, 3 x 40 bits, then lanes 0 and 3 together (pointer now 3)
      add_block(2, 3, 40, 0);
      run_quiet(200);
      add_block(0, 1, -1, 0);
      add_block(3, 1, -1, 0);
      run_quiet(200);

      // five-cycle back-pressure after the first beat
      stall_req = 1;
      add_block(3, 4, -1, 0);
      run_quiet(200);

      // single-beat block with a stray s_valid during its transfer
      spur_req = 1;
      add_block(1, 1, -1, 0);
      run_quiet(200);

      // reset while draining lane 1, then lanes 0 and 3 race from pointer 0
      add_block(1, 2, -1, 0);
      n = 0;
      while ((phase != M_DRAIN) && (n < 100)) begin step(); n++; end
      chk("reach_drain", DW'(phase), DW'(M_DRAIN));
      do_reset();
      step();
      chk("post_rst_busy", DW'(busy_o), '0);
      add_block(0, 1, -1, 0);
      add_block(3, 1, -1, 0);
      run_quiet(200);

      // protocol errors: missing sop, then a repeated sop
      add_block(2, 2, -1, 1);
      run_quiet(200);
      do_reset();
      add_block(1, 3, -1, 2);
      run_quiet(200);
      do_reset();

`ifdef BPC_ARB_STATS_EN
      add_block(0, 4, 128, 0);
      add_block(0, 1, 64, 0);
      run_quiet(200);
      chk("stat_blk_l0", DW'(stat_blk_o[CW-1:0]), DW'(2));
      chk("stat_bits_l0", DW'(stat_bits_o[CW+TW-1:0]), DW'(576));
`endif

      // randomized traffic: gaps, back-pressure, variable drain delay
      gap_pct = 30; ready_pct = 75; max_delay = 3;
      for (int i = 0; i < 200; i++) add_block($urandom_range(N - 1), $urandom_range(1, 4), -1, 0);
      run_quiet(20000);
      chk("blk_outstanding", DW'(exp_q.size()), '0);
`ifdef BPC_ARB_STATS_EN
      for (int k = 0; k < N; k++) begin
         chk("stat_blk", DW'(stat_blk_o[k*CW +: CW]), DW'(m_blk[k]));
         chk("stat_bits", DW'(stat_bits_o[k*(CW+TW) +: (CW+TW)]), DW'(m_bits[k]));
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
